id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised RV32I decode stage with an integrated ID/EX pipeline register. It sits between the fetch stage and the execute stage. It decodes one instruction per accepted handshake and resolves operands from N forwarding ports or the register file. It detects load-use hazards and stalls on them, honours downstream backpressure and flushes, and flags illegal encodings instead of silently turning them into NOPs.

## Interface
- `XLEN`, 32, datapath and immediate width.
- `FWD_PORTS`, 2, number of forwarding sources. Port 0 is the youngest stage (EX), and higher indices are older stages.
- `REG_AW`, 5, register address width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid` / `in_ready`  in / out  1 / 1  fetch-side handshake.
- `pc_i` / `inst_i`  in  XLEN / 32  PC and instruction of the fetched word.
- `reg1_addr_o` / `reg2_addr_o`  out  REG_AW  combinational regfile read addresses: rs1 = `inst_i[19:15]`, rs2 = `inst_i[24:20]`.
- `reg1_data_i` / `reg2_data_i`  in  XLEN  combinational regfile read data.
- `fwd_wreg_i`  in  FWD_PORTS  per-port write-enable.
- `fwd_wd_i`  in  FWD_PORTS*REG_AW  per-port destination register; port k occupies bits [k*REG_AW +: REG_AW].
- `fwd_wdata_i`  in  FWD_PORTS*XLEN  per-port result data.
- `fwd0_is_load_i`  in  1  port 0 holds a load whose data is not yet available.
- `flush_i`  in  1  kill the held output and any instruction accepted in the same cycle.
- `out_valid` / `out_ready`  out / in  1 / 1  execute-side handshake.
- `pc_o`  out  XLEN  registered PC.
- `aluop_o`  out  3  registered decode field, shared-defines encoding.
- `alusel_o`  out  5  registered decode field, shared-defines encoding.
- `imm_o`, `reg1_o`, `reg2_o`  out  XLEN  registered immediate and operands.
- `wreg_o`  out  1  registered register-write enable.
- `wd_o`  out  REG_AW  registered destination register.
- `illegal_o`  out  1  registered illegal-encoding flag.

## Operation
**Decode** covers LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
- Immediates use the I, S, B, U and J formats, sign-extended to XLEN.
- Source usage:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
- `wreg_o = 1` only for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, and only when rd != 0.
- OP-IMM shifts: SRLI when `funct7 = 0x00`, SRAI when `funct7 = 0x20`, illegal otherwise. SLLI requires `funct7 = 0x00`.
- OP: ADD/SUB and SRL/SRA are selected by `funct7[5]`. Any `funct7` other than 0x00 or 0x20 is illegal.

**Illegal encodings** include an unknown opcode, unused funct3 in BRANCH/LOAD/STORE, and JALR funct3 != 0.
- Output: `illegal_o = 1`, NOP aluop/alusel, `wreg_o = 0`, `out_valid = 1`, with `pc_o` preserved.

**Operands**
- An unused source yields 0.
- x0 always yields 0 and is never forwarded.
- Otherwise the lowest-index port k with `fwd_wreg_i[k]` set and a matching `fwd_wd_i` wins; with no match, regfile data is used.

**Load-use hazard**: `fwd0_is_load_i & fwd_wreg_i[0]`, `fwd_wd_i[0] != 0`, and `fwd_wd_i[0]` equal to a *used* source.

**Ready and advance**
- `in_ready = !rst & !hazard & (!out_valid | out_ready)`.
- The output register advances when `!out_valid | out_ready`:
  - on an accepted instruction, it loads the decode and sets `out_valid = 1`;
  - otherwise it clears `out_valid`, inserting a bubble.
- When `out_valid & !out_ready`, all outputs hold exactly.

**Flush**
- `flush_i` forces `out_valid = 0` on the next edge.
- `in_ready` is forced to 1 during a flush cycle, so a presented instruction is consumed and discarded.
- Flush overrides hazard and backpressure.

**Reset**: `out_valid`, `pc_o`, `aluop_o`, `alusel_o`, `imm_o`, `reg1_o`, `reg2_o`, `wreg_o`, `wd_o` and `illegal_o` are all 0. `in_ready` is 0 while `rst` is high. Reset mid-stall drops the held instruction.

## Timing
- Latency is 1 cycle: accepted at edge n, visible with `out_valid` after edge n.
- Throughput is 1 instruction per cycle with no hazard and `out_ready` high.
- Operands are sampled at the accepting edge. The forwarding values present in that cycle are the ones captured.
- A load-use hazard costs exactly one bubble when port 0 advances the following cycle.
- Purely combinational paths:
  - `in_ready` from `out_ready`, the forwarding inputs, `inst_i` and `flush_i`;
  - `reg*_addr_o` from `inst_i`.

## Test plan
- **Reset:** `rst = 1` for 2 cycles with `in_valid = 1` -> `in_ready = 0`, `out_valid = 0`, all outputs 0.
- **ADDI:** `0x00700293` (ADDI x5, x0, 7) -> next cycle `wd_o = 5`, `wreg_o = 1`, `imm_o = 7`, `reg1_o = 0`, `illegal_o = 0`.
- **Forwarding priority:** `0x002081B3` (ADD x3, x1, x2) with port0 {x1, 0x11}, port1 {x1, 0x22}, port1' {x2, 0x33}, regfile 0xAA/0xBB.
  - Port1' is the same port 1 carrying x2 on a second beat.
  - Required result: `reg1_o = 0x11`, `reg2_o = 0x33`.
- **Load-use:** port0 load to x1 while the ADD above is presented.
  - Required: `in_ready = 0` and a bubble.
  - When `fwd0_is_load_i` drops, accept with forwarded data.
- **Backpressure and flush:** hold `out_ready = 0` for 3 cycles -> outputs stable, `in_ready = 0`. Then assert `flush_i` -> `out_valid = 0` next edge.
- **Illegal and SRAI:** `0xFFFFFFFF` -> `illegal_o = 1`, `wreg_o = 0`. `0x40325213` -> SRAI alusel, `imm_o[4:0] = 3`.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I decode with operand forwarding, load-use stall and ID/EX register.
module id_stage_pipe #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned FWD_PORTS = 2,
   parameter int unsigned REG_AW    = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [XLEN-1:0]             pc_i,
   input  logic [31:0]                 inst_i,
   output logic [REG_AW-1:0]           reg1_addr_o,
   output logic [REG_AW-1:0]           reg2_addr_o,
   input  logic [XLEN-1:0]             reg1_data_i,
   input  logic [XLEN-1:0]             reg2_data_i,
   input  logic [FWD_PORTS-1:0]        fwd_wreg_i,
   input  logic [FWD_PORTS*REG_AW-1:0] fwd_wd_i,
   input  logic [FWD_PORTS*XLEN-1:0]   fwd_wdata_i,
   input  logic                        fwd0_is_load_i,
   input  logic                        flush_i,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [XLEN-1:0]             pc_o,
   output logic [2:0]                  aluop_o,
   output logic [4:0]                  alusel_o,
   output logic [XLEN-1:0]             imm_o,
   output logic [XLEN-1:0]             reg1_o,
   output logic [XLEN-1:0]             reg2_o,
   output logic                        wreg_o,
   output logic [REG_AW-1:0]           wd_o,
   output logic                        illegal_o
);

   // Opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Shared ALU operation classes
   localparam logic [2:0] AOP_NOP    = 3'd0;
   localparam logic [2:0] AOP_ARITH  = 3'd1;
   localparam logic [2:0] AOP_LOGIC  = 3'd2;
   localparam logic [2:0] AOP_SHIFT  = 3'd3;
   localparam logic [2:0] AOP_BRANCH = 3'd4;
   localparam logic [2:0] AOP_JUMP   = 3'd5;
   localparam logic [2:0] AOP_LOAD   = 3'd6;
   localparam logic [2:0] AOP_STORE  = 3'd7;

   // Shared ALU selectors
   localparam logic [4:0] SEL_NOP   = 5'd0;
   localparam logic [4:0] SEL_ADD   = 5'd1;
   localparam logic [4:0] SEL_SUB   = 5'd2;
   localparam logic [4:0] SEL_SLT   = 5'd3;
   localparam logic [4:0] SEL_SLTU  = 5'd4;
   localparam logic [4:0] SEL_AND   = 5'd5;
   localparam logic [4:0] SEL_OR    = 5'd6;
   localparam logic [4:0] SEL_XOR   = 5'd7;
   localparam logic [4:0] SEL_SLL   = 5'd8;
   localparam logic [4:0] SEL_SRL   = 5'd9;
   localparam logic [4:0] SEL_SRA   = 5'd10;
   localparam logic [4:0] SEL_LUI   = 5'd11;
   localparam logic [4:0] SEL_AUIPC = 5'd12;
   localparam logic [4:0] SEL_JAL   = 5'd13;
   localparam logic [4:0] SEL_JALR  = 5'd14;
   localparam logic [4:0] SEL_BEQ   = 5'd15;
   localparam logic [4:0] SEL_LB    = 5'd21;
   localparam logic [4:0] SEL_SB    = 5'd26;

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic [REG_AW-1:0] rd;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];
   assign funct7 = inst_i[31:25];
   assign rs1    = REG_AW'(inst_i[19:15]);
   assign rs2    = REG_AW'(inst_i[24:20]);
   assign rd     = REG_AW'(inst_i[11:7]);

   assign reg1_addr_o = rs1;
   assign reg2_addr_o = rs2;

   logic signed [31:0] imm32;
   logic [2:0]         d_aluop;
   logic [4:0]         d_alusel;
   logic [XLEN-1:0]    d_imm;
   logic               d_use1;
   logic               d_use2;
   logic               d_wr;
   logic               d_illegal;
   logic               d_wreg;
   logic [REG_AW-1:0]  d_wd;

   // Instruction decode; illegal encodings collapse to a flagged NOP
   always_comb begin
      imm32     = '0;
      d_aluop   = AOP_NOP;
      d_alusel  = SEL_NOP;
      d_use1    = 1'b0;
      d_use2    = 1'b0;
      d_wr      = 1'b0;
      d_illegal = 1'b0;
      unique case (opcode)
         OPC_LUI: begin
            imm32    = {inst_i[31:12], 12'b0};
            d_aluop  = AOP_ARITH;
            d_alusel = SEL_LUI;
            d_wr     = 1'b1;
         end
         OPC_AUIPC: begin
            imm32    = {inst_i[31:12], 12'b0};
            d_aluop  = AOP_ARITH;
            d_alusel = SEL_AUIPC;
            d_wr     = 1'b1;
         end
         OPC_JAL: begin
            imm32    = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            d_aluop  = AOP_JUMP;
            d_alusel = SEL_JAL;
            d_wr     = 1'b1;
         end
         OPC_JALR: begin
            imm32     = {{20{inst_i[31]}}, inst_i[31:20]};
            d_aluop   = AOP_JUMP;
            d_alusel  = SEL_JALR;
            d_use1    = 1'b1;
            d_wr      = 1'b1;
            d_illegal = (funct3 != 3'd0);
         end
         OPC_BRANCH: begin
            imm32     = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            d_aluop   = AOP_BRANCH;
            d_use1    = 1'b1;
            d_use2    = 1'b1;
            d_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            // BEQ, BNE, BLT, BGE, BLTU, BGEU map to consecutive selectors
            d_alusel  = (funct3[2] ? SEL_BEQ + 5'd2 + 5'(funct3[1:0]) : SEL_BEQ + 5'(funct3[0]));
         end
         OPC_LOAD: begin
            imm32     = {{20{inst_i[31]}}, inst_i[31:20]};
            d_aluop   = AOP_LOAD;
            d_use1    = 1'b1;
            d_wr      = 1'b1;
            d_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            // LB, LH, LW, LBU, LHU
            d_alusel  = funct3[2] ? SEL_LB + 5'd3 + 5'(funct3[0]) : SEL_LB + 5'(funct3[1:0]);
         end
         OPC_STORE: begin
            imm32     = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            d_aluop   = AOP_STORE;
            d_use1    = 1'b1;
            d_use2    = 1'b1;
            d_illegal = (funct3 > 3'd2);
            d_alusel  = SEL_SB + 5'(funct3[1:0]);
         end
         OPC_OPIMM: begin
            imm32   = {{20{inst_i[31]}}, inst_i[31:20]};
            d_aluop = AOP_ARITH;
            d_use1  = 1'b1;
            d_wr    = 1'b1;
            unique case (funct3)
               3'd0: d_alusel = SEL_ADD;
               3'd2: d_alusel = SEL_SLT;
               3'd3: d_alusel = SEL_SLTU;
               3'd4: begin d_aluop = AOP_LOGIC; d_alusel = SEL_XOR; end
               3'd6: begin d_aluop = AOP_LOGIC; d_alusel = SEL_OR;  end
               3'd7: begin d_aluop = AOP_LOGIC; d_alusel = SEL_AND; end
               3'd1: begin
                  d_aluop   = AOP_SHIFT;
                  d_alusel  = SEL_SLL;
                  d_illegal = (funct7 != 7'h00);
               end
               default: begin
                  d_aluop   = AOP_SHIFT;
                  d_alusel  = (funct7 == 7'h20) ? SEL_SRA : SEL_SRL;
                  d_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
               end
            endcase
         end
         OPC_OP: begin
            d_aluop   = AOP_ARITH;
            d_use1    = 1'b1;
            d_use2    = 1'b1;
            d_wr      = 1'b1;
            d_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
            unique case (funct3)
               3'd0: d_alusel = funct7[5] ? SEL_SUB : SEL_ADD;
               3'd5: begin d_aluop = AOP_SHIFT; d_alusel = funct7[5] ? SEL_SRA : SEL_SRL; end
               3'd1: begin d_aluop = AOP_SHIFT; d_alusel = SEL_SLL; d_illegal = (funct7 != 7'h00); end
               3'd2: begin d_alusel = SEL_SLT;  d_illegal = (funct7 != 7'h00); end
               3'd3: begin d_alusel = SEL_SLTU; d_illegal = (funct7 != 7'h00); end
               3'd4: begin d_aluop = AOP_LOGIC; d_alusel = SEL_XOR; d_illegal = (funct7 != 7'h00); end
               3'd6: begin d_aluop = AOP_LOGIC; d_alusel = SEL_OR;  d_illegal = (funct7 != 7'h00); end
               default: begin d_aluop = AOP_LOGIC; d_alusel = SEL_AND; d_illegal = (funct7 != 7'h00); end
            endcase
         end
         default: d_illegal = 1'b1;
      endcase
      if (d_illegal) begin
         imm32    = '0;
         d_aluop  = AOP_NOP;
         d_alusel = SEL_NOP;
         d_use1   = 1'b0;
         d_use2   = 1'b0;
         d_wr     = 1'b0;
      end
   end

   assign d_imm  = XLEN'(imm32);
   assign d_wreg = d_wr && (rd != '0);
   assign d_wd   = d_wreg ? rd : '0;

   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;

   // Operand select: lowest-index matching forward port wins, x0 and unused read as zero
   always_comb begin
      op1 = reg1_data_i;
      op2 = reg2_data_i;
      for (int k = FWD_PORTS - 1; k >= 0; k--) begin
         if (fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == rs1)) op1 = fwd_wdata_i[k*XLEN +: XLEN];
         if (fwd_wreg_i[k] && (fwd_wd_i[k*REG_AW +: REG_AW] == rs2)) op2 = fwd_wdata_i[k*XLEN +: XLEN];
      end
      if (!d_use1 || (rs1 == '0)) op1 = '0;
      if (!d_use2 || (rs2 == '0)) op2 = '0;
   end

   logic [REG_AW-1:0] wd0;
   logic              hazard;
   logic              advance;
   logic              accept;

   assign wd0     = fwd_wd_i[REG_AW-1:0];
   assign hazard  = fwd0_is_load_i && fwd_wreg_i[0] && (wd0 != '0) &&
                    ((d_use1 && (wd0 == rs1)) || (d_use2 && (wd0 == rs2)));
   assign advance = !out_valid || out_ready;
   assign in_ready = !rst && (flush_i || (!hazard && advance));
   assign accept  = in_valid && in_ready;

   // ID/EX register: load on accept, bubble on idle advance, hold under backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         pc_o      <= '0;
         aluop_o   <= '0;
         alusel_o  <= '0;
         imm_o     <= '0;
         reg1_o    <= '0;
         reg2_o    <= '0;
         wreg_o    <= 1'b0;
         wd_o      <= '0;
         illegal_o <= 1'b0;
      end else if (flush_i) begin
         out_valid <= 1'b0;
      end else if (advance) begin
         out_valid <= accept;
         if (accept) begin
            pc_o      <= pc_i;
            aluop_o   <= d_aluop;
            alusel_o  <= d_alusel;
            imm_o     <= d_imm;
            reg1_o    <= op1;
            reg2_o    <= op2;
            wreg_o    <= d_wreg;
            wd_o      <= d_wd;
            illegal_o <= d_illegal;
         end
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vectors with a scoreboard queue and decoupled output monitor.
module tb_id_stage_pipe;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  aluop;
      logic [4:0]  alusel;
      logic [31:0] imm;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic        wreg;
      logic [4:0]  wd;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc_i;
   logic [31:0] inst_i;
   logic [4:0]  reg1_addr_o;
   logic [4:0]  reg2_addr_o;
   logic [31:0] reg1_data_i;
   logic [31:0] reg2_data_i;
   logic [1:0]  fwd_wreg_i;
   logic [9:0]  fwd_wd_i;
   logic [63:0] fwd_wdata_i;
   logic        fwd0_is_load_i;
   logic        flush_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc_o;
   logic [2:0]  aluop_o;
   logic [4:0]  alusel_o;
   logic [31:0] imm_o;
   logic [31:0] reg1_o;
   logic [31:0] reg2_o;
   logic        wreg_o;
   logic [4:0]  wd_o;
   logic        illegal_o;

   int checks   = 0;
   int failures = 0;
   exp_t exp_q[$];

   id_stage_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pc_i(pc_i), .inst_i(inst_i),
      .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
      .fwd0_is_load_i(fwd0_is_load_i), .flush_i(flush_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o), .imm_o(imm_o),
      .reg1_o(reg1_o), .reg2_o(reg2_o), .wreg_o(wreg_o), .wd_o(wd_o),
      .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] pc, input logic [2:0] aop, input logic [4:0] sel,
                               input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2,
                               input logic wr, input logic [4:0] wd, input logic ill);
      exp_t e;
      e.pc = pc; e.aluop = aop; e.alusel = sel; e.imm = imm; e.reg1 = r1; e.reg2 = r2;
      e.wreg = wr; e.wd = wd; e.illegal = ill;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   // After an active edge, move to the drive point
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Present one instruction, push its expected result when it is accepted
   task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input exp_t e, input string name);
      bit done = 0;
      in_valid = 1'b1;
      inst_i   = inst;
      pc_i     = pc;
      for (int c = 0; c < 10 && !done; c++) begin
         #1;
         if (in_ready) begin
            exp_q.push_back(e);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL %s: not accepted within 10 cycles", name);
      end
   endtask

   // Monitor: compare every output handshake against the scoreboard head
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            exp_t got;
            exp_t want;
            got = '{pc_o, aluop_o, alusel_o, imm_o, reg1_o, reg2_o, wreg_o, wd_o, illegal_o};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output: got pc=0x%0h with empty scoreboard", pc_o);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  failures++;
                  $display("FAIL out_pc_%0h: got aop=%0d sel=%0d imm=%0h r1=%0h r2=%0h wr=%0b wd=%0d ill=%0b pc=%0h, expected aop=%0d sel=%0d imm=%0h r1=%0h r2=%0h wr=%0b wd=%0d ill=%0b pc=%0h",
                           want.pc, got.aluop, got.alusel, got.imm, got.reg1, got.reg2, got.wreg, got.wd, got.illegal, got.pc,
                           want.aluop, want.alusel, want.imm, want.reg1, want.reg2, want.wreg, want.wd, want.illegal, want.pc);
               end
            end
         end
      end
   end

   localparam logic [31:0] ADDI_X5  = 32'h00700293;
   localparam logic [31:0] ADD_X3   = 32'h002081B3;
   localparam logic [31:0] SUB_X6   = 32'h40208333;
   localparam logic [31:0] MUL_X3   = 32'h022081B3;
   localparam logic [31:0] SW_X2    = 32'h0020A423;
   localparam logic [31:0] JAL_X1   = 32'hFF9FF0EF;
   localparam logic [31:0] SRAI_X4  = 32'h40325213;
   localparam logic [31:0] ALL_ONES = 32'hFFFFFFFF;

   initial begin
      exp_t sw_e;
      rst = 1'b1; in_valid = 1'b1; inst_i = ADDI_X5; pc_i = 32'h1000;
      reg1_data_i = 32'hAA; reg2_data_i = 32'hBB;
      fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd0_is_load_i = 1'b0;
      flush_i = 1'b0; out_ready = 1'b1;

      // Reset held for two cycles with a valid instruction presented
      for (int i = 0; i < 2; i++) begin
         step();
         chk("reset_in_ready", 64'(in_ready), 64'd0);
         chk("reset_out_valid", 64'(out_valid), 64'd0);
         chk("reset_outputs_zero",
             64'(|{pc_o, aluop_o, alusel_o, imm_o, reg1_o, reg2_o, wreg_o, wd_o, illegal_o}), 64'd0);
      end
      rst = 1'b0; in_valid = 1'b0;
      step();

      issue(ADDI_X5, 32'h1000, mk(32'h1000, 3'd1, 5'd1, 32'd7, 32'd0, 32'd0, 1'b1, 5'd5, 1'b0), "addi");

      // Port 0 and port 1 both carry x1: port 0 wins; rs2 from regfile
      fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'h22, 32'h11};
      issue(ADD_X3, 32'h1004, mk(32'h1004, 3'd1, 5'd1, 32'd0, 32'h11, 32'hBB, 1'b1, 5'd3, 1'b0), "fwd_prio_a");
      // Second beat: port 1 now carries x2
      fwd_wd_i = {5'd2, 5'd1}; fwd_wdata_i = {32'h33, 32'h11};
      issue(ADD_X3, 32'h1008, mk(32'h1008, 3'd1, 5'd1, 32'd0, 32'h11, 32'h33, 1'b1, 5'd3, 1'b0), "fwd_prio_b");

      // Load-use: port 0 load to x1 while ADD x3,x1,x2 is presented
      fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd1}; fwd_wdata_i = {32'h0, 32'h99}; fwd0_is_load_i = 1'b1;
      in_valid = 1'b1; inst_i = ADD_X3; pc_i = 32'h100C;
      #1;
      chk("loaduse_in_ready", 64'(in_ready), 64'd0);
      step();
      chk("loaduse_bubble", 64'(out_valid), 64'd0);
      fwd0_is_load_i = 1'b0; fwd_wdata_i = {32'h0, 32'h44};
      issue(ADD_X3, 32'h100C, mk(32'h100C, 3'd1, 5'd1, 32'd0, 32'h44, 32'hBB, 1'b1, 5'd3, 1'b0), "loaduse_fwd");
      fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;
      step();
      step();

      // Backpressure: held output stays put and stalls the input
      out_ready = 1'b0;
      sw_e = mk(32'h2000, 3'd7, 5'd28, 32'd8, 32'hAA, 32'hBB, 1'b0, 5'd0, 1'b0);
      issue(SW_X2, 32'h2000, sw_e, "bp_store");
      in_valid = 1'b1; inst_i = JAL_X1; pc_i = 32'h2004;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_pc_imm", {pc_o, imm_o}, {32'h2000, 32'd8});
         chk("bp_hold_ops", {reg1_o, reg2_o}, {32'hAA, 32'hBB});
         step();
      end
      // Flush kills the held store and consumes the presented JAL
      flush_i = 1'b1;
      #1;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      step();
      flush_i = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      out_ready = 1'b1;
      step();
      chk("flush_discarded", 64'(out_valid), 64'd0);

      // Remaining decode vectors back to back
      issue(JAL_X1, 32'h3000, mk(32'h3000, 3'd5, 5'd13, 32'hFFFFFFF8, 32'd0, 32'd0, 1'b1, 5'd1, 1'b0), "jal");
      issue(SRAI_X4, 32'h3004, mk(32'h3004, 3'd3, 5'd10, 32'h403, 32'hAA, 32'd0, 1'b1, 5'd4, 1'b0), "srai");
      issue(SUB_X6, 32'h3008, mk(32'h3008, 3'd1, 5'd2, 32'd0, 32'hAA, 32'hBB, 1'b1, 5'd6, 1'b0), "sub");
      issue(MUL_X3, 32'h300C, mk(32'h300C, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1), "bad_funct7");
      issue(ALL_ONES, 32'h3010, mk(32'h3010, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1), "illegal_ones");
      issue(SW_X2, 32'h3014, mk(32'h3014, 3'd7, 5'd28, 32'd8, 32'hAA, 32'hBB, 1'b0, 5'd0, 1'b0), "sw");

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      step();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
